// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: access-mode encodings,
// arbiter state and grant enumerations, and the watchdog counter width helper.
package mem_arbiter_pkg;

    // Access-mode encoding carried on d_mode / mem_mode.
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_I,
        ARB_BUSY_D
    } arb_state_e;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_e;

    // Watchdog counter width: enough to hold TIMEOUT, never narrower than 1 bit.
    function automatic int unsigned wd_width(input int unsigned timeout);
        int unsigned w;
        w = (timeout == 0) ? 1 : $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog for the memory arbiter.
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   en_i      a transaction is in flight
//   clear_i   restart the count (held while the arbiter is idle)
//   tick_i    a busy cycle passed without memory completion
//   expire_o  this is the last busy cycle the transaction is allowed
// TIMEOUT = 0 disables the watchdog entirely.
module arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic expire_o
);

    localparam int unsigned CW = wd_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);
        cnt_d    = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if ((TIMEOUT != 0) && tick_i && !expire_o) begin
            // Expiry ends the transaction, so the count never wraps.
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the core's single memory port between
// instruction fetch (I, read-only) and the load/store unit (D, read/write).
// One transaction in flight at a time; attributes are registered at grant.
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request and address
//   i_rdata/i_ready/i_err    fetch data, completion pulse, timeout-abort pulse
//   d_req/d_wen/d_mode/...   LSU request, store enable, access mode, address, data
//   d_rdata/d_ready/d_err    load data, completion pulse, timeout-abort pulse
//   mem_*                    memory-side transaction interface
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_ready,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_wen,
    input  logic [2:0]      d_mode,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_ready,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_wen,
    output logic [2:0]      mem_mode,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_dat_o,
    input  logic [XLEN-1:0] mem_dat_i,
    input  logic            mem_ready
);

    arb_state_e      state_q, state_d;
    grant_e          last_q, last_d;
    logic            mem_wen_q, mem_wen_d;
    logic [2:0]      mem_mode_q, mem_mode_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_dat_q, mem_dat_d;

    logic busy;
    logic wd_expire;
    logic gnt_i;
    logic gnt_d;

    assign busy = (state_q != ARB_IDLE);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (busy),
        .clear_i  (!busy),
        .tick_i   (busy && !mem_ready),
        .expire_o (wd_expire)
    );

    // On a tie, the port that did not win last time gets the grant.
    assign gnt_d = d_req && (!i_req || (last_q == GNT_I));
    assign gnt_i = i_req && (!d_req || (last_q == GNT_D));

    // Requester-side responses; mem_ready only matters while busy, and a
    // same-cycle completion suppresses the timeout abort.
    always_comb begin
        mem_req   = busy;
        mem_wen   = mem_wen_q;
        mem_mode  = mem_mode_q;
        mem_addr  = mem_addr_q;
        mem_dat_o = mem_dat_q;
        i_ready   = mem_ready && (state_q == ARB_BUSY_I);
        d_ready   = mem_ready && (state_q == ARB_BUSY_D);
        i_err     = wd_expire && !mem_ready && (state_q == ARB_BUSY_I);
        d_err     = wd_expire && !mem_ready && (state_q == ARB_BUSY_D);
        i_rdata   = i_ready ? mem_dat_i : '0;
        d_rdata   = d_ready ? mem_dat_i : '0;
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        mem_wen_d  = mem_wen_q;
        mem_mode_d = mem_mode_q;
        mem_addr_d = mem_addr_q;
        mem_dat_d  = mem_dat_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_d) begin
                    state_d    = ARB_BUSY_D;
                    last_d     = GNT_D;
                    mem_wen_d  = d_wen;
                    mem_mode_d = d_mode;
                    mem_addr_d = d_addr;
                    mem_dat_d  = d_wdata;
                end else if (gnt_i) begin
                    state_d    = ARB_BUSY_I;
                    last_d     = GNT_I;
                    mem_wen_d  = 1'b0;
                    mem_mode_d = MODE_W;
                    mem_addr_d = i_addr;
                    // Fetches never write; drop stale store data.
                    mem_dat_d  = '0;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                // Always return to IDLE: no back-to-back grants.
                if (mem_ready || wd_expire) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_q     <= GNT_I;
            mem_wen_q  <= 1'b0;
            mem_mode_q <= '0;
            mem_addr_q <= '0;
            mem_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            mem_wen_q  <= mem_wen_d;
            mem_mode_q <= mem_mode_d;
            mem_addr_q <= mem_addr_d;
            mem_dat_q  <= mem_dat_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// fairness and timeout sequences, then randomized traffic against a
// transaction-level reference model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wen, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_dat_i;
    logic [2:0]  d_mode;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_dat_o;
    logic        i_ready, i_err, d_ready, d_err, mem_req, mem_wen;
    logic [2:0]  mem_mode;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .XLEN    (32),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_mode    (d_mode),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_mode  (mem_mode),
        .mem_addr  (mem_addr),
        .mem_dat_o (mem_dat_o),
        .mem_dat_i (mem_dat_i),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ireq;
        logic [31:0] iaddr;
        logic        dreq, dwen;
        logic [2:0]  dmode;
        logic [31:0] daddr, dwdata;
        logic        mrdy;
        logic [31:0] mdat;
    } vin_t;

    typedef struct {
        logic        mreq, attr, mwen;
        logic [2:0]  mmode;
        logic [31:0] maddr, mdato;
        logic        irdy, ierr, drdy, derr;
    } vex_t;

    typedef struct {
        vin_t i;
        vex_t e;
    } vec_t;

    vec_t tbl[$];

    function automatic vin_t vi(input int unsigned r, ir, ia, dr, dw, dm, da, dd, mr, md);
        vin_t v;
        v.rst = 1'(r);  v.ireq = 1'(ir); v.iaddr = ia;
        v.dreq = 1'(dr); v.dwen = 1'(dw); v.dmode = 3'(dm);
        v.daddr = da;   v.dwdata = dd;  v.mrdy = 1'(mr); v.mdat = md;
        return v;
    endfunction

    // attr = 1: check mem_wen/mode/addr (and mem_dat_o when it is meaningful).
    function automatic vex_t ve(input int unsigned mq, at, mw, mm, ma, mo, ir, ie, dr, de);
        vex_t v;
        v.mreq = 1'(mq); v.attr = 1'(at); v.mwen = 1'(mw); v.mmode = 3'(mm);
        v.maddr = ma;    v.mdato = mo;
        v.irdy = 1'(ir); v.ierr = 1'(ie); v.drdy = 1'(dr); v.derr = 1'(de);
        return v;
    endfunction

    function automatic vec_t row(input vin_t a, input vex_t b);
        vec_t r;
        r.i = a;
        r.e = b;
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_wen = 0; d_mode = 0;
        d_addr = 0; d_wdata = 0; mem_ready = 0; mem_dat_i = 0;
    endtask

    // Returns just after a reset edge with rst low and inputs idle.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] modes [5];
        int n, busy_cnt;
        bit prev_done, got;
        int owner, age, last;
        logic [31:0] l_addr, l_wdata;
        logic l_wen;
        logic [2:0] l_mode;
        bit ip, dp, e_rdy, e_err;

        modes[0] = 3'b000; modes[1] = 3'b001; modes[2] = 3'b010;
        modes[3] = 3'b100; modes[4] = 3'b101;

        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);

        // ---------------- directed vector table ----------------
        // single fetch, memory answers one cycle after mem_req
        tbl.push_back(row(vi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h1000, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h1000, 0, 0, 0, 0, 0, 0, 0),
                          ve(1, 1, 0, 2, 'h1000, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h1000, 0, 0, 0, 0, 0, 1, 'hDEAD_BEEF),
                          ve(1, 1, 0, 2, 'h1000, 0, 1, 0, 0, 0)));
        tbl.push_back(row(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        // simultaneous after reset: D store first, then the fetch
        tbl.push_back(row(vi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h1000, 1, 1, 0, 'h2000, 'h1234_5678, 0, 0),
                          ve(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h1000, 1, 1, 0, 'h2000, 'h1234_5678, 0, 0),
                          ve(1, 1, 1, 0, 'h2000, 'h1234_5678, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h1000, 1, 1, 0, 'h2000, 'h1234_5678, 1, 'hAAAA_5555),
                          ve(1, 1, 1, 0, 'h2000, 'h1234_5678, 0, 0, 1, 0)));
        tbl.push_back(row(vi(0, 1, 'h1000, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h1000, 0, 0, 0, 0, 0, 0, 0),
                          ve(1, 1, 0, 2, 'h1000, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h1000, 0, 0, 0, 0, 0, 1, 'h0BAD_F00D),
                          ve(1, 1, 0, 2, 'h1000, 0, 1, 0, 0, 0)));
        tbl.push_back(row(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        // completion in the same cycle the watchdog would expire
        tbl.push_back(row(vi(0, 0, 0, 1, 0, 4, 'h3000, 0, 0, 0),
                          ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(row(vi(0, 0, 0, 1, 0, 4, 'h3000, 0, 0, 0),
                              ve(1, 1, 0, 4, 'h3000, 0, 0, 0, 0, 0)));
        end
        tbl.push_back(row(vi(0, 0, 0, 1, 0, 4, 'h3000, 0, 1, 'h55AA_55AA),
                          ve(1, 1, 0, 4, 'h3000, 0, 0, 0, 1, 0)));
        tbl.push_back(row(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        // reset mid BUSY_I drops the fetch silently, then D wins the tie
        tbl.push_back(row(vi(0, 1, 'h4000, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h4000, 0, 0, 0, 0, 0, 0, 0),
                          ve(1, 1, 0, 2, 'h4000, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(1, 1, 'h4000, 0, 0, 0, 0, 0, 0, 0),
                          ve(1, 1, 0, 2, 'h4000, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h4000, 1, 0, 1, 'h5000, 0, 0, 0),
                          ve(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h4000, 1, 0, 1, 'h5000, 0, 1, 'h1357_9BDF),
                          ve(1, 1, 0, 1, 'h5000, 0, 0, 0, 1, 0)));
        tbl.push_back(row(vi(0, 1, 'h4000, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(vi(0, 1, 'h4000, 0, 0, 0, 0, 0, 1, 'h2468_ACE0),
                          ve(1, 1, 0, 2, 'h4000, 0, 1, 0, 0, 0)));
        tbl.push_back(row(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

        foreach (tbl[k]) begin
            @(posedge clk); #1;
            rst = tbl[k].i.rst;     i_req = tbl[k].i.ireq;   i_addr = tbl[k].i.iaddr;
            d_req = tbl[k].i.dreq;  d_wen = tbl[k].i.dwen;   d_mode = tbl[k].i.dmode;
            d_addr = tbl[k].i.daddr; d_wdata = tbl[k].i.dwdata;
            mem_ready = tbl[k].i.mrdy; mem_dat_i = tbl[k].i.mdat;
            @(negedge clk);
            chk1($sformatf("vec%0d mem_req", k), mem_req, tbl[k].e.mreq);
            chk1($sformatf("vec%0d i_ready", k), i_ready, tbl[k].e.irdy);
            chk1($sformatf("vec%0d i_err", k), i_err, tbl[k].e.ierr);
            chk1($sformatf("vec%0d d_ready", k), d_ready, tbl[k].e.drdy);
            chk1($sformatf("vec%0d d_err", k), d_err, tbl[k].e.derr);
            chk32($sformatf("vec%0d i_rdata", k), i_rdata,
                  tbl[k].e.irdy ? tbl[k].i.mdat : 32'h0);
            chk32($sformatf("vec%0d d_rdata", k), d_rdata,
                  tbl[k].e.drdy ? tbl[k].i.mdat : 32'h0);
            if (tbl[k].e.attr) begin
                chk1($sformatf("vec%0d mem_wen", k), mem_wen, tbl[k].e.mwen);
                chk32($sformatf("vec%0d mem_mode", k), 32'(mem_mode), 32'(tbl[k].e.mmode));
                chk32($sformatf("vec%0d mem_addr", k), mem_addr, tbl[k].e.maddr);
                if (tbl[k].e.mwen || !tbl[k].e.mreq) begin
                    chk32($sformatf("vec%0d mem_dat_o", k), mem_dat_o, tbl[k].e.mdato);
                end
            end
        end

        // ---------------- fairness: both ports always requesting ----------------
        do_reset();
        i_req = 1; i_addr = 32'h1000;
        d_req = 1; d_wen = 0; d_mode = 3'b010; d_addr = 32'h2000;
        mem_ready = 1; mem_dat_i = 32'hCAFE_0001;
        n = 0;
        prev_done = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (prev_done) chk1($sformatf("fair idle gap %0d", n), mem_req, 1'b0);
            prev_done = 0;
            if (i_ready || d_ready) begin
                chk32($sformatf("fair grant %0d {d,i}", n), {30'h0, d_ready, i_ready},
                      (n % 2 == 0) ? 32'h2 : 32'h1);
                n++;
                prev_done = 1;
            end
            @(posedge clk); #1;
        end
        chk32("fair completions", n, 6);

        // ---------------- watchdog abort of a D load ----------------
        do_reset();
        d_req = 1; d_wen = 0; d_mode = 3'b010; d_addr = 32'h6000;
        busy_cnt = 0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (mem_req) busy_cnt++;
            chk1("to d_ready low", d_ready, 1'b0);
            if (d_err) begin
                chk32("to err busy cycle", busy_cnt, 4);
                got = 1;
            end
            @(posedge clk); #1;
        end
        chk1("to err seen", got, 1'b1);
        d_req = 0; i_req = 1; i_addr = 32'h7000;
        @(negedge clk);
        chk1("to mem_req drop", mem_req, 1'b0);
        chk1("to d_err single", d_err, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("to next grant", mem_req, 1'b1);
        chk32("to next addr", mem_addr, 32'h7000);
        @(posedge clk); #1;
        mem_ready = 1; mem_dat_i = 32'h7777_0000;
        @(negedge clk);
        chk1("to next ready", i_ready, 1'b1);
        chk32("to next rdata", i_rdata, 32'h7777_0000);

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        owner = 0; age = 0; last = 1;
        ip = 0; dp = 0;
        l_addr = 0; l_wdata = 0; l_wen = 0; l_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!ip) ip = ($urandom_range(0, 2) == 0);
            if (!dp) dp = ($urandom_range(0, 2) == 0);
            i_req = ip; i_addr = $urandom;
            d_req = dp; d_wen = 1'($urandom_range(0, 1));
            d_mode = modes[$urandom_range(0, 4)];
            d_addr = $urandom; d_wdata = $urandom;
            mem_ready = (owner != 0) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
            mem_dat_i = $urandom;
            @(negedge clk);
            e_rdy = (owner != 0) && mem_ready;
            e_err = (owner != 0) && !mem_ready && (age == TO - 1);
            chk1("rnd mem_req", mem_req, owner != 0);
            chk1("rnd i_ready", i_ready, (owner == 1) && e_rdy);
            chk1("rnd d_ready", d_ready, (owner == 2) && e_rdy);
            chk1("rnd i_err", i_err, (owner == 1) && e_err);
            chk1("rnd d_err", d_err, (owner == 2) && e_err);
            chk32("rnd i_rdata", i_rdata, ((owner == 1) && e_rdy) ? mem_dat_i : 32'h0);
            chk32("rnd d_rdata", d_rdata, ((owner == 2) && e_rdy) ? mem_dat_i : 32'h0);
            if (owner != 0) begin
                chk32("rnd mem_addr", mem_addr, l_addr);
                chk1("rnd mem_wen", mem_wen, l_wen);
                chk32("rnd mem_mode", 32'(mem_mode), 32'(l_mode));
                if (l_wen) chk32("rnd mem_dat_o", mem_dat_o, l_wdata);
            end
            // advance the model across the coming clock edge
            if (owner == 0) begin
                if (i_req || d_req) begin
                    owner = (i_req && d_req) ? ((last == 1) ? 2 : 1) : (d_req ? 2 : 1);
                    last  = owner;
                    age   = 0;
                    if (owner == 2) begin
                        l_addr = d_addr; l_wen = d_wen; l_mode = d_mode; l_wdata = d_wdata;
                    end else begin
                        l_addr = i_addr; l_wen = 0; l_mode = 3'b010; l_wdata = 0;
                    end
                end
            end else if (e_rdy || e_err) begin
                if (owner == 1) ip = 0;
                else dp = 0;
                owner = 0;
            end else begin
                age++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
